// File: rtl/b1to8_demuxer_hs_if.sv
// rtl/b1to8_demuxer_hs_if.sv - handshake and slot-output bundle for the 1-to-8 serial demuxer
interface b1to8_demuxer_hs_if;
    logic       x0;
    logic [2:0] b2_b0;
    logic       auto;
    logic       clr;
    logic       dav_;
    logic       rfd;
    logic [7:0] z7_z0;
    logic       full;
    logic [2:0] ptr;

    modport master (
        output x0, b2_b0, auto, clr, dav_,
        input  rfd, z7_z0, full, ptr
    );

    modport slave (
        input  x0, b2_b0, auto, clr, dav_,
        output rfd, z7_z0, full, ptr
    );
endinterface

// File: rtl/b1to8_demuxer_hs.sv
// rtl/b1to8_demuxer_hs.sv - 1-to-8 serial bit demuxer with dav_/rfd handshake (optional TRISTATE_OUT_EN)
module b1to8_demuxer_hs (
    input  logic                  clock,
    input  logic                  reset_,
    b1to8_demuxer_hs_if.slave     bus
);
    typedef enum logic {ATTESA, FINE} state_t;

    state_t     state;
    logic [7:0] d;
    logic [7:0] v;
    logic [2:0] p;
    logic       rfd_q;
    logic       armed;
    logic [2:0] a;

    assign a = bus.auto ? p : bus.b2_b0;

    // armed blocks a strobe still held low across reset release from capturing
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= ATTESA;
            rfd_q <= 1'b1;
            d     <= 8'h00;
            v     <= 8'h00;
            p     <= 3'd0;
            armed <= 1'b0;
        end else begin
            if (bus.dav_)
                armed <= 1'b1;
            case (state)
                ATTESA: begin
                    if (!bus.dav_ && armed) begin
                        d[a]  <= bus.x0;
                        v[a]  <= 1'b1;
                        rfd_q <= 1'b0;
                        state <= FINE;
                    end else begin
                        rfd_q <= 1'b1;
                    end
                end
                FINE: begin
                    if (bus.dav_) begin
                        rfd_q <= 1'b1;
                        state <= ATTESA;
                        if (bus.auto)
                            p <= p + 3'd1;
                    end else begin
                        rfd_q <= 1'b0;
                    end
                end
                default: state <= ATTESA;
            endcase
            // clear wins over a same-edge capture or pointer increment
            if (bus.clr) begin
                v <= 8'h00;
                p <= 3'd0;
            end
        end
    end

    assign bus.rfd  = rfd_q;
    assign bus.full = &v;
    assign bus.ptr  = p;

`ifdef TRISTATE_OUT_EN
    for (genvar i = 0; i < 8; i++) begin : g_slot
        assign bus.z7_z0[i] = v[i] ? d[i] : 1'bz;
    end
`else
    assign bus.z7_z0 = d;
`endif
endmodule

// File: tb/tb_b1to8_demuxer_hs.sv
// tb/tb_b1to8_demuxer_hs.sv - directed scoreboard bench for b1to8_demuxer_hs
module tb_b1to8_demuxer_hs;
    logic clock;
    logic reset_;

    b1to8_demuxer_hs_if bus ();

    b1to8_demuxer_hs dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic       rfd;
        logic [7:0] z;
        logic       full;
        logic [2:0] ptr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic       m_fine, m_arm, m_rfd;
    logic [7:0] m_d, m_v;
    logic [2:0] m_p;

    function automatic logic [7:0] exp_z(input logic [7:0] dd, input logic [7:0] vv);
        logic [7:0] r;
`ifdef TRISTATE_OUT_EN
        for (int i = 0; i < 8; i++) r[i] = vv[i] ? dd[i] : 1'bz;
`else
        r = dd;
        if (vv == 8'h00) r = dd;
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_fine = 1'b0; m_arm = 1'b0; m_rfd = 1'b1;
        m_d = 8'h00; m_v = 8'h00; m_p = 3'd0;
    endtask

    task automatic model_edge(input logic dav, input logic x, input logic au,
                              input logic [2:0] b, input logic c);
        logic [2:0] a;
        logic       was_arm;
        was_arm = m_arm;
        if (dav) m_arm = 1'b1;
        if (!m_fine) begin
            if (!dav && was_arm) begin
                a = au ? m_p : b;
                m_d[a] = x;
                m_v[a] = 1'b1;
                m_rfd = 1'b0;
                m_fine = 1'b1;
            end else m_rfd = 1'b1;
        end else if (dav) begin
            m_rfd = 1'b1;
            m_fine = 1'b0;
            if (au) m_p = m_p + 3'd1;
        end else m_rfd = 1'b0;
        if (c) begin m_v = 8'h00; m_p = 3'd0; end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag; e.rfd = m_rfd; e.z = exp_z(m_d, m_v); e.full = &m_v; e.ptr = m_p;
        q.push_back(e);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) begin
            checks++; errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = q.pop_front();
            chk1({e.tag, "_rfd"}, bus.rfd, e.rfd);
            chk8({e.tag, "_z"}, bus.z7_z0, e.z);
            chk1({e.tag, "_full"}, bus.full, e.full);
            chk8({e.tag, "_ptr"}, {5'd0, bus.ptr}, {5'd0, e.ptr});
        end
    endtask

    task automatic step(input string tag, input logic dav, input logic x, input logic au,
                        input logic [2:0] b, input logic c);
        @(negedge clock);
        bus.dav_ = dav; bus.x0 = x; bus.auto = au; bus.b2_b0 = b; bus.clr = c;
        @(posedge clock);
        model_edge(dav, x, au, b, c);
        push_exp(tag);
        #1;
        check_out();
    endtask

    logic [7:0] rr_bits;

    initial begin
        reset_ = 1'b0;
        bus.dav_ = 1'b1; bus.x0 = 1'b0; bus.auto = 1'b0; bus.b2_b0 = 3'd0; bus.clr = 1'b0;
        #12;
        model_reset();
        push_exp("reset");
        check_out();
        chk1("reset_rfd_const", bus.rfd, 1'b1);
        chk1("reset_full_const", bus.full, 1'b0);
        @(negedge clock);
        reset_ = 1'b1;
        step("idle", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step("idle2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

        // addressed write to slot 5
        step("addr_cap", 1'b0, 1'b1, 1'b0, 3'd5, 1'b0);
        chk1("addr_z5_const", bus.z7_z0[5], 1'b1);
        chk1("addr_rfd_low", bus.rfd, 1'b0);
        step("addr_rel", 1'b1, 1'b0, 1'b0, 3'd5, 1'b0);
        chk1("addr_rfd_high", bus.rfd, 1'b1);
        step("clr1", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);

        // round-robin fill of all eight slots
        rr_bits = 8'b01001101;
        for (int i = 0; i < 8; i++) begin
            step("rr_cap", 1'b0, rr_bits[i], 1'b1, 3'd7 - 3'(i), 1'b0);
            step("rr_rel", 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
            if (i == 7) chk8("rr_ptr_wrap", {5'd0, bus.ptr}, 8'd0);
        end
        chk8("rr_z_const", bus.z7_z0, 8'b01001101);
        chk1("rr_full_const", bus.full, 1'b1);
        step("rr_overwrite", 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        chk1("rr_full_kept", bus.full, 1'b1);
        step("rr_ow_rel", 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);

        // clr coincident with capture at pointer 3
        step("clr2", 1'b1, 1'b0, 1'b1, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("pre_cap", 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
            step("pre_rel", 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
        end
        chk8("pre_ptr3", {5'd0, bus.ptr}, 8'd3);
        step("clrcap", 1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
        chk1("clrcap_full", bus.full, 1'b0);
        chk1("clrcap_rfd", bus.rfd, 1'b0);
        step("clrcap_rel", 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);

        // held strobe with toggling data
        for (int i = 0; i < 5; i++)
            step("held", 1'b0, 1'(i % 2 == 0), 1'b1, 3'd0, 1'b0);
        step("held_rel", 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);

        // reset asserted while in FINE with dav_ still low
        step("mid_cap", 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        reset_ = 1'b0;
        #1;
        model_reset();
        push_exp("mid_reset");
        check_out();
        @(negedge clock);
        reset_ = 1'b1;
        step("mid_hold1", 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        step("mid_hold2", 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        chk8("mid_no_cap", bus.z7_z0, exp_z(8'h00, 8'h00));
        step("mid_high", 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
        step("mid_recap", 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
        chk1("mid_recap_z2", bus.z7_z0[2], 1'b1);
        step("mid_rel", 1'b1, 1'b0, 1'b0, 3'd2, 1'b0);

        chk8("scoreboard_drained", 8'(q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
